// File: rtl/vram_sram_responder.sv
// NAK-handshake responder that turns each accepted request into one timed
// asynchronous-SRAM read or write cycle on the 48-bit framebuffer SRAM.
module vram_sram_responder #(
  parameter int unsigned ADDR_BITS    = 20,
  parameter int unsigned READ_CYCLES  = 2,
  parameter int unsigned WRITE_CYCLES = 2
) (
  input  logic                 clkMem,
  input  logic                 rst,
  input  logic                 wb_stb,
  input  logic [31:0]          wb_addr,
  input  logic [3:0]           wb_we,
  input  logic [31:0]          wb_din,
  output logic [47:0]          wb_dout,
  output logic                 wb_nak,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic [5:0]           sram_be_n,
  output logic [47:0]          sram_dq_o,
  output logic                 sram_dq_oe,
  input  logic [47:0]          sram_dq_i
);

  localparam int unsigned MAX_CYC = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACK, ACCESS, DATA} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               is_write, is_write_nx;
  logic               nak_nx, ce_nx, oe_nx, we_nx, dqoe_nx;
  logic [5:0]         be_nx;
  logic [ADDR_BITS-1:0] addr_nx;
  logic [47:0]        dqo_nx, dout_nx;

  generate
    if (ADDR_BITS < 32) begin : g_addr_unused
      logic unused_addr_hi;
      assign unused_addr_hi = ^wb_addr[31:ADDR_BITS];
    end
  endgenerate

  always_ff @(posedge clkMem) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (wb_stb) state_nx = ACK;
      ACK:     state_nx = ACCESS;
      ACCESS:  if (cnt == '0) state_nx = DATA;
      DATA:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of every registered output; unassigned fields hold.
  always_comb begin
    nak_nx      = wb_nak;
    ce_nx       = sram_ce_n;
    oe_nx       = sram_oe_n;
    we_nx       = sram_we_n;
    be_nx       = sram_be_n;
    addr_nx     = sram_addr;
    dqo_nx      = sram_dq_o;
    dqoe_nx     = sram_dq_oe;
    dout_nx     = wb_dout;
    cnt_nx      = cnt;
    is_write_nx = is_write;
    case (state)
      IDLE: begin
        nak_nx = 1'b1;
        if (wb_stb) begin
          nak_nx      = 1'b0;
          ce_nx       = 1'b0;
          addr_nx     = wb_addr[ADDR_BITS-1:0];
          is_write_nx = |wb_we;
          if (|wb_we) begin
            cnt_nx  = WR_LOAD;
            be_nx   = {2'b11, ~wb_we};
            dqo_nx  = {16'h0000, wb_din};
            dqoe_nx = 1'b1;
          end else begin
            cnt_nx = RD_LOAD;
            be_nx  = '0;
          end
        end
      end
      ACK: begin
        nak_nx = 1'b1;
        if (is_write) we_nx = 1'b0;
        else          oe_nx = 1'b0;
      end
      ACCESS: begin
        if (cnt == '0) begin
          nak_nx = 1'b0;
          oe_nx  = 1'b1;
          we_nx  = 1'b1;
          ce_nx  = 1'b1;
          if (!is_write) dout_nx = sram_dq_i;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      DATA: begin
        nak_nx  = 1'b1;
        dqoe_nx = 1'b0;
        be_nx   = '1;
      end
      default: nak_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clkMem) begin
    if (rst) begin
      wb_nak     <= 1'b1;
      wb_dout    <= '0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= '1;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      cnt        <= '0;
      is_write   <= 1'b0;
    end else begin
      wb_nak     <= nak_nx;
      wb_dout    <= dout_nx;
      sram_ce_n  <= ce_nx;
      sram_oe_n  <= oe_nx;
      sram_we_n  <= we_nx;
      sram_be_n  <= be_nx;
      sram_addr  <= addr_nx;
      sram_dq_o  <= dqo_nx;
      sram_dq_oe <= dqoe_nx;
      cnt        <= cnt_nx;
      is_write   <= is_write_nx;
    end
  end

endmodule

// File: tb/tb_vram_sram_responder.sv
// Scoreboarded bench for vram_sram_responder: single accesses, scan-out
// read burst, back-to-back requests, mid-access reset and address wrap.
module tb_vram_sram_responder;

  localparam int unsigned AB = 20;
  localparam int unsigned RC = 2;
  localparam int unsigned WC = 2;

  logic          clkMem = 1'b0;
  logic          rst;
  logic          wb_stb;
  logic [31:0]   wb_addr;
  logic [3:0]    wb_we;
  logic [31:0]   wb_din;
  logic [47:0]   wb_dout;
  logic          wb_nak;
  logic [AB-1:0] sram_addr;
  logic          sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe;
  logic [5:0]    sram_be_n;
  logic [47:0]   sram_dq_o, sram_dq_i;

  int n_cmp = 0;
  int n_bad = 0;
  logic [47:0] exp_q[$];
  logic [47:0] model_dout;

  // Captures from the last do_req transaction
  int          r_ok, r_acc_cyc, r_nak_hi, r_oe_lo, r_we_lo, r_dqoe_hi, r_overlap;
  logic [5:0]  r_acc_ben, r_post_ben;
  logic        r_post_dqoe, r_post_nak;
  logic [47:0] r_dout, r_dqo;
  logic [AB-1:0] r_addr;

  always #5 clkMem = ~clkMem;

  function automatic logic [47:0] model_word(input logic [AB-1:0] a);
    if (a == 20'h12345) return 48'hABCD_1234_5678;
    return {8'h5A, a, a ^ 20'hFFFFF};
  endfunction

  assign sram_dq_i = sram_oe_n ? 48'h0 : model_word(sram_addr);

  vram_sram_responder #(.ADDR_BITS(AB), .READ_CYCLES(RC), .WRITE_CYCLES(WC)) dut (
    .clkMem(clkMem), .rst(rst), .wb_stb(wb_stb), .wb_addr(wb_addr), .wb_we(wb_we),
    .wb_din(wb_din), .wb_dout(wb_dout), .wb_nak(wb_nak), .sram_addr(sram_addr),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_be_n(sram_be_n), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i)
  );

  task automatic do_req(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    int cyc;
    r_ok = 0; r_acc_cyc = 0; r_nak_hi = 0; r_oe_lo = 0; r_we_lo = 0;
    r_dqoe_hi = 0; r_overlap = 0;
    if (w == 4'h0) model_dout = model_word(a[AB-1:0]);
    exp_q.push_back(model_dout);
    wb_stb = 1'b1; wb_addr = a; wb_we = w; wb_din = d;
    cyc = 0;
    do begin @(posedge clkMem); #1; cyc++; end while (wb_nak !== 1'b0 && cyc < 20);
    if (wb_nak !== 1'b0) begin
      wb_stb = 1'b0;
      return;
    end
    r_acc_cyc = cyc;
    r_acc_ben = sram_be_n;
    if (sram_dq_oe === 1'b1) r_dqoe_hi++;
    // scramble inputs: must not affect the access in flight
    wb_stb = 1'b0; wb_addr = ~a; wb_we = ~w; wb_din = ~d;
    cyc = 0;
    do begin
      @(posedge clkMem); #1; cyc++;
      if (wb_nak === 1'b0) break;
      r_nak_hi++;
      if (sram_oe_n === 1'b0) r_oe_lo++;
      if (sram_we_n === 1'b0) r_we_lo++;
      if (sram_dq_oe === 1'b1) r_dqoe_hi++;
      if (sram_oe_n === 1'b0 && sram_we_n === 1'b0) r_overlap++;
    end while (cyc < 20);
    if (wb_nak !== 1'b0) return;
    r_dout = wb_dout; r_addr = sram_addr; r_dqo = sram_dq_o;
    if (sram_dq_oe === 1'b1) r_dqoe_hi++;
    @(posedge clkMem); #1;
    r_post_ben = sram_be_n; r_post_dqoe = sram_dq_oe; r_post_nak = wb_nak;
    wb_addr = '0; wb_we = '0; wb_din = '0;
    r_ok = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clkMem);
    #1;
    n_cmp++; if (wb_nak !== 1'b1) begin n_bad++; $display("FAIL rst_nak: got %b want 1", wb_nak); end
    n_cmp++; if (wb_dout !== 48'h0) begin n_bad++; $display("FAIL rst_dout: got %h want 0", wb_dout); end
    n_cmp++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 4'b1110) begin
      n_bad++; $display("FAIL rst_ctl: got %b want 1110", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}); end
    n_cmp++; if (sram_be_n !== 6'h3F) begin n_bad++; $display("FAIL rst_be: got %h want 3f", sram_be_n); end
    n_cmp++; if (sram_addr !== '0 || sram_dq_o !== 48'h0) begin
      n_bad++; $display("FAIL rst_addr_dq: got %h/%h want 0/0", sram_addr, sram_dq_o); end
    rst = 1'b0;
    model_dout = '0;
    @(posedge clkMem); #1;
  endtask

  task automatic test_read();
    logic [47:0] e;
    do_req(32'h0001_2345, 4'h0, 32'h0);
    e = exp_q.pop_front();
    n_cmp++; if (r_ok !== 1) begin n_bad++; $display("FAIL rd_done: got %0d want 1", r_ok); end
    n_cmp++; if (r_acc_cyc !== 1) begin n_bad++; $display("FAIL rd_accept_lat: got %0d want 1", r_acc_cyc); end
    n_cmp++; if (r_nak_hi !== RC) begin n_bad++; $display("FAIL rd_nak_high: got %0d want %0d", r_nak_hi, RC); end
    n_cmp++; if (r_oe_lo !== RC) begin n_bad++; $display("FAIL rd_oe_low: got %0d want %0d", r_oe_lo, RC); end
    n_cmp++; if (r_dout !== e) begin n_bad++; $display("FAIL rd_dout: got %h want %h", r_dout, e); end
    n_cmp++; if (r_addr !== 20'h12345) begin n_bad++; $display("FAIL rd_addr: got %h want 12345", r_addr); end
    n_cmp++; if (r_acc_ben !== 6'h00) begin n_bad++; $display("FAIL rd_be: got %b want 000000", r_acc_ben); end
    n_cmp++; if (r_we_lo !== 0 || r_dqoe_hi !== 0) begin
      n_bad++; $display("FAIL rd_no_drive: we_low %0d dq_oe %0d want 0/0", r_we_lo, r_dqoe_hi); end
    n_cmp++; if (r_post_nak !== 1'b1 || r_post_ben !== 6'h3F) begin
      n_bad++; $display("FAIL rd_post: nak %b be %h want 1/3f", r_post_nak, r_post_ben); end
  endtask

  task automatic test_write();
    logic [47:0] e;
    do_req(32'h0000_0010, 4'b0101, 32'hDEADBEEF);
    e = exp_q.pop_front();
    n_cmp++; if (r_ok !== 1) begin n_bad++; $display("FAIL wr_done: got %0d want 1", r_ok); end
    n_cmp++; if (r_acc_ben !== 6'b111010) begin n_bad++; $display("FAIL wr_be: got %b want 111010", r_acc_ben); end
    n_cmp++; if (r_we_lo !== WC) begin n_bad++; $display("FAIL wr_we_low: got %0d want %0d", r_we_lo, WC); end
    n_cmp++; if (r_oe_lo !== 0 || r_overlap !== 0) begin
      n_bad++; $display("FAIL wr_oe: oe_low %0d overlap %0d want 0/0", r_oe_lo, r_overlap); end
    n_cmp++; if (r_dqoe_hi !== 2 + WC) begin n_bad++; $display("FAIL wr_dq_oe: got %0d want %0d", r_dqoe_hi, 2 + WC); end
    n_cmp++; if (r_dqo !== 48'h0000_DEAD_BEEF) begin n_bad++; $display("FAIL wr_dq_o: got %h want 0000deadbeef", r_dqo); end
    n_cmp++; if (r_addr !== 20'h00010) begin n_bad++; $display("FAIL wr_addr: got %h want 00010", r_addr); end
    n_cmp++; if (r_dout !== e) begin n_bad++; $display("FAIL wr_dout_kept: got %h want %h", r_dout, e); end
    n_cmp++; if (r_post_dqoe !== 1'b0 || r_post_ben !== 6'h3F) begin
      n_bad++; $display("FAIL wr_post: dq_oe %b be %h want 0/3f", r_post_dqoe, r_post_ben); end
  endtask

  task automatic test_reset_mid_write();
    logic [47:0] e;
    wb_stb = 1'b1; wb_addr = 32'h0000_0222; wb_we = 4'hF; wb_din = 32'h1234_5678;
    @(posedge clkMem); #1;
    wb_stb = 1'b0;
    @(posedge clkMem); #1;
    n_cmp++; if (sram_we_n !== 1'b0) begin n_bad++; $display("FAIL mid_we_active: got %b want 0", sram_we_n); end
    rst = 1'b1;
    @(posedge clkMem); #1;
    rst = 1'b0;
    n_cmp++; if ({sram_we_n, sram_ce_n, sram_dq_oe, wb_nak} !== 4'b1101) begin
      n_bad++; $display("FAIL mid_rst_ctl: got %b want 1101", {sram_we_n, sram_ce_n, sram_dq_oe, wb_nak}); end
    n_cmp++; if (wb_dout !== 48'h0) begin n_bad++; $display("FAIL mid_rst_dout: got %h want 0", wb_dout); end
    model_dout = '0;
    do_req(32'h0000_0777, 4'h0, 32'h0);
    e = exp_q.pop_front();
    n_cmp++; if (r_ok !== 1 || r_acc_cyc !== 1) begin
      n_bad++; $display("FAIL mid_next_read: done %0d accept %0d want 1/1", r_ok, r_acc_cyc); end
    n_cmp++; if (r_dout !== e) begin n_bad++; $display("FAIL mid_next_dout: got %h want %h", r_dout, e); end
  endtask

  task automatic test_addr_wrap();
    logic [47:0] e;
    do_req(32'hFFF0_0003, 4'h0, 32'h0);
    e = exp_q.pop_front();
    n_cmp++; if (r_addr !== 20'h00003) begin n_bad++; $display("FAIL wrap_addr: got %h want 00003", r_addr); end
    n_cmp++; if (r_dout !== e) begin n_bad++; $display("FAIL wrap_dout: got %h want %h", r_dout, e); end
  endtask

  task automatic test_vga_scan();
    logic [47:0] e;
    logic [31:0] base;
    int bad_before;
    bad_before = n_bad;
    base = 32'd3 * 32'd640;
    for (int x = 0; x < 640; x++) begin
      do_req(base + 32'(x), 4'h0, 32'h0);
      e = exp_q.pop_front();
      n_cmp++; if (r_ok !== 1 || r_nak_hi !== RC) begin
        n_bad++; $display("FAIL vga_handshake x=%0d: done %0d nak_high %0d want 1/%0d", x, r_ok, r_nak_hi, RC); end
      n_cmp++; if (r_dout !== e || r_addr !== AB'(base + 32'(x))) begin
        n_bad++; $display("FAIL vga_word x=%0d: got %h@%h want %h@%h", x, r_dout, r_addr, e, AB'(base + 32'(x))); end
      if (n_bad - bad_before > 8) break;
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] e;
    int pulses, accepts, comps, dbl, first_comp, second_acc;
    logic prev_low, accept_next;
    exp_q.push_back(model_word(20'h00400));
    exp_q.push_back(model_word(20'h00401));
    model_dout = model_word(20'h00401);
    pulses = 0; accepts = 0; comps = 0; dbl = 0; first_comp = -1; second_acc = -1;
    prev_low = 1'b0; accept_next = 1'b1;
    wb_stb = 1'b1; wb_addr = 32'h0000_0400; wb_we = 4'h0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clkMem); #1;
      if (wb_nak === 1'b0) begin
        pulses++;
        if (prev_low) dbl++;
        if (accept_next) begin
          accepts++;
          if (accepts == 1) wb_addr = 32'h0000_0401;
          if (accepts == 2) begin second_acc = c; wb_stb = 1'b0; end
        end else begin
          comps++;
          if (comps == 1) first_comp = c;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++; if (wb_dout !== e) begin n_bad++; $display("FAIL b2b_dout%0d: got %h want %h", comps, wb_dout, e); end
          end
        end
        accept_next = ~accept_next;
      end
      prev_low = (wb_nak === 1'b0);
    end
    wb_addr = '0;
    n_cmp++; if (pulses !== 4 || accepts !== 2) begin
      n_bad++; $display("FAIL b2b_pulses: got %0d pulses %0d accepts want 4/2", pulses, accepts); end
    n_cmp++; if (dbl !== 0) begin n_bad++; $display("FAIL b2b_merged: got %0d want 0", dbl); end
    n_cmp++; if (second_acc - first_comp !== 2) begin
      n_bad++; $display("FAIL b2b_gap: got %0d want 2", second_acc - first_comp); end
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL b2b_pending: got %0d want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wb_stb = 1'b0; wb_addr = '0; wb_we = '0; wb_din = '0;
    model_dout = '0;
    test_reset();
    test_read();
    test_write();
    test_reset_mid_write();
    test_addr_wrap();
    test_vga_scan();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
